pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush scheduler for the 5-stage pipeline (IF/ID/EX/MEM/WB). It detects load-use hazards that the operand forwarding network cannot cover, and sequences multi-cycle EX operations (mul/div) through a start/finish handshake. It also holds the pipeline during data-memory waits and issues branch/exception flushes. It drives the per-stage stall and bubble controls plus the forwarding network's operand-hold enable.

Parameters:
EX_TIMEOUT, 64, cycles in EX_WAIT before ex_timeout asserts; 0 disables the watchdog
CNT_W, 16, width of the saturating stall-cycle performance counter

Ports:
aclk  in  1  clock; all state on rising edge
aresetn  in  1  asynchronous active-low reset
rj_no_id, rk_no_id, rd_no_id  in  Gr each  ID-stage source register numbers
rj_use_id, rk_use_id, rd_use_id  in  1 each  ID instruction reads that source
rd_no_ex  in  Gr  EX destination register
regWriteEn_ex  in  1  EX instruction writes the register file
memRead_ex  in  1  EX instruction is a load
ex_multi  in  1  EX instruction is multi-cycle
ex_finish  in  1  multi-cycle unit result valid (level)
mem_req  in  1  MEM stage has an outstanding access
mem_data_ok  in  1  data memory response, 1-cycle pulse
branch_taken_ex  in  1  EX resolved a taken branch/jump
excp_flush  in  1  exception/ertn from WB
stall_if, stall_id, stall_ex, stall_mem  out  1 each  hold the stage register
bubble_ex  out  1  load a NOP into the ID/EX register
flush_if, flush_id  out  1 each  kill the stage contents
ex_start  out  1  1-cycle start pulse to the multi-cycle unit
fwd_hold  out  1  forwarding network latches EX operands while high
ex_timeout  out  1  sticky; watchdog expired
stall_cnt  out  CNT_W  saturating count of cycles with stall_id=1

Behaviour:
- Reset (async, aresetn=0): state=RUN, all outputs 0, stall_cnt=0, watchdog=0, ex_timeout=0. Deassertion is taken synchronously at the next edge.
- Load-use hazard (combinational):
  - lu = memRead_ex & regWriteEn_ex & rd_no_ex!=0 & ((rj_use_id & rj_no_id==rd_no_ex) | (rk_use_id & rk_no_id==rd_no_ex) | (rd_use_id & rd_no_id==rd_no_ex)).
- FSM states: RUN, EX_WAIT, MEM_WAIT.
- RUN:
  - ex_multi=1 → ex_start=1 this cycle, stall_if/id/ex=1; next state EX_WAIT.
  - mem_req & ~mem_data_ok → stall_if/id/ex/mem=1; next state MEM_WAIT.
  - lu=1 → stall_if=stall_id=1, bubble_ex=1 for exactly one cycle.
- EX_WAIT:
  - stall_if/id/ex=1 and fwd_hold=1; ex_start=0.
  - ex_finish=1 → stalls drop in the same cycle and the state returns to RUN.
  - Watchdog increments each cycle. When it reaches EX_TIMEOUT, ex_timeout sets (sticky until reset); the state stays EX_WAIT.
- MEM_WAIT:
  - All of stall_if/id/ex/mem=1.
  - mem_data_ok=1 → stalls drop in the same cycle and the state returns to RUN.
  - If ex_multi is still asserted, EX_WAIT is entered next with an ex_start pulse.
- Priority, highest first: excp_flush > MEM wait > EX wait > branch_taken_ex > lu.
- excp_flush:
  - flush_if=flush_id=bubble_ex=1; all stalls 0; next state RUN; watchdog cleared.
  - Exception: a pending MEM_WAIT holds until mem_data_ok, so a response is never dropped; flush_if and flush_id are still asserted.
- branch_taken_ex (no higher event): flush_if=flush_id=1 and bubble_ex=1 for one cycle. Any simultaneous lu is ignored because the ID instruction is dead.
- ex_multi together with branch_taken_ex: EX_WAIT is entered first; the flush is issued in the cycle ex_finish is seen.
- ex_start never re-pulses while in EX_WAIT, and never pulses twice for the same instruction.
- stall_cnt increments when stall_id=1 and saturates at all-ones.
- All outputs except ex_timeout and stall_cnt are combinational from state and inputs; there is no added latency.

Decomposition:
- Shared package cpuDefine holds:
  - Gr (5-bit) and DType (32-bit), both existing;
  - new enum HazState_t {RUN, EX_WAIT, MEM_WAIT};
  - new struct StageCtrl_t {stall, flush} per stage.
- One sub-module is natural: hazard_watchdog, holding the EX_TIMEOUT counter and sticky flag. Everything else stays in pipe_hazard_ctrl.

Test Plan:
- Load-use: ld.w r4 in EX (memRead_ex=1, rd_no_ex=4), ID add with rj_no_id=4, rj_use_id=1 → one cycle of stall_if=stall_id=bubble_ex=1, then RUN with outputs 0. Repeat with rd_no_ex=0 → no stall.
- Divide: ex_multi=1, ex_finish rises after 10 cycles → ex_start high exactly in cycle 0; stall_if/id/ex and fwd_hold high for 10 cycles then low; stall_cnt=11.
- Mem wait plus branch: mem_req=1, mem_data_ok after 3 cycles, branch_taken_ex held → 3 stall cycles with no flush; flush_if/flush_id in the cycle mem_data_ok=1.
- Exception during EX_WAIT: excp_flush at cycle 4 → flush_if=flush_id=bubble_ex=1, stalls 0, state RUN next cycle, watchdog cleared.
- Watchdog: EX_TIMEOUT=8, ex_finish never asserts → ex_timeout=1 at cycle 8 and stays 1. Assert aresetn=0 mid-wait → all outputs 0 immediately, without waiting for a clock edge.
- Saturation: CNT_W=4 with continuous stall → stall_cnt reaches 15 and holds.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared CPU types for the pipeline hazard controller
package cpuDefine;

  typedef logic [4:0]  Gr;
  typedef logic [31:0] DType;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    EX_WAIT  = 2'd1,
    MEM_WAIT = 2'd2
  } HazState_t;

  typedef struct packed {
    logic stall;
    logic flush;
  } StageCtrl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - pipeline <-> hazard controller signal bundle
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 16);
  import cpuDefine::*;

  Gr                rj_no_id;
  Gr                rk_no_id;
  Gr                rd_no_id;
  logic             rj_use_id;
  logic             rk_use_id;
  logic             rd_use_id;
  Gr                rd_no_ex;
  logic             regWriteEn_ex;
  logic             memRead_ex;
  logic             ex_multi;
  logic             ex_finish;
  logic             mem_req;
  logic             mem_data_ok;
  logic             branch_taken_ex;
  logic             excp_flush;

  logic             stall_if;
  logic             stall_id;
  logic             stall_ex;
  logic             stall_mem;
  logic             bubble_ex;
  logic             flush_if;
  logic             flush_id;
  logic             ex_start;
  logic             fwd_hold;
  logic             ex_timeout;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output rj_no_id, rk_no_id, rd_no_id, rj_use_id, rk_use_id, rd_use_id,
    output rd_no_ex, regWriteEn_ex, memRead_ex, ex_multi, ex_finish,
    output mem_req, mem_data_ok, branch_taken_ex, excp_flush,
    input  stall_if, stall_id, stall_ex, stall_mem, bubble_ex,
    input  flush_if, flush_id, ex_start, fwd_hold, ex_timeout, stall_cnt
  );

  modport slave (
    input  rj_no_id, rk_no_id, rd_no_id, rj_use_id, rk_use_id, rd_use_id,
    input  rd_no_ex, regWriteEn_ex, memRead_ex, ex_multi, ex_finish,
    input  mem_req, mem_data_ok, branch_taken_ex, excp_flush,
    output stall_if, stall_id, stall_ex, stall_mem, bubble_ex,
    output flush_if, flush_id, ex_start, fwd_hold, ex_timeout, stall_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_watchdog.sv
// rtl/pipe_hazard_ctrl_watchdog.sv - multi-cycle EX watchdog with sticky timeout flag
module hazard_watchdog #(
  parameter int EX_TIMEOUT = 64
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic run,
  input  logic clr,
  output logic timeout
);

  localparam int            W      = (EX_TIMEOUT > 1) ? $clog2(EX_TIMEOUT + 1) : 1;
  localparam logic [W-1:0]  LIMIT  = W'(EX_TIMEOUT);
  localparam bit            ENABLE = (EX_TIMEOUT != 0);

  logic [W-1:0] cnt;

  // Counts cycles since the multi-cycle op launched; parks at LIMIT so it never wraps.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      if (clr || !run) begin
        cnt <= '0;
      end else if (cnt != LIMIT) begin
        cnt <= cnt + W'(1);
      end
      if (ENABLE && run && !clr && (cnt != LIMIT) && (cnt + W'(1) == LIMIT)) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush scheduler for the 5-stage pipeline
module pipe_hazard_ctrl
  import cpuDefine::*;
#(
  parameter int EX_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic                aclk,
  input  logic                aresetn,
  pipe_hazard_ctrl_if.slave   hz
);

  HazState_t        state;
  HazState_t        state_nxt;
  StageCtrl_t       ctl_if;
  StageCtrl_t       ctl_id;
  StageCtrl_t       ctl_ex;
  logic             stall_mem_c;
  logic             ex_start_c;
  logic             fwd_hold_c;
  logic             lu;
  logic             in_ex;
  logic             mem_busy;
  logic             ev_excp;
  logic             ev_mem;
  logic             ev_exwait;
  logic             ev_start;
  logic             ev_free;
  logic             ev_br;
  logic             ev_lu;
  logic [CNT_W-1:0] stall_cnt_q;

  assign lu = hz.memRead_ex & hz.regWriteEn_ex & (hz.rd_no_ex != '0) &
              ((hz.rj_use_id & (hz.rj_no_id == hz.rd_no_ex)) |
               (hz.rk_use_id & (hz.rk_no_id == hz.rd_no_ex)) |
               (hz.rd_use_id & (hz.rd_no_id == hz.rd_no_ex)));

  // Once in MEM_WAIT the access is outstanding until the response pulse, whatever mem_req does.
  assign in_ex    = (state == EX_WAIT);
  assign mem_busy = (state == MEM_WAIT) ? ~hz.mem_data_ok : (hz.mem_req & ~hz.mem_data_ok);

  // Mutually exclusive events in priority order; finishing EX_WAIT falls through to branch/lu.
  assign ev_excp   = hz.excp_flush;
  assign ev_mem    = ~ev_excp & mem_busy & ~in_ex;
  assign ev_exwait = ~ev_excp & in_ex & (~hz.ex_finish | mem_busy);
  assign ev_start  = ~ev_excp & ~mem_busy & ~in_ex & hz.ex_multi;
  assign ev_free   = ~ev_excp & ~ev_mem & ~ev_exwait & ~ev_start;
  assign ev_br     = ev_free & hz.branch_taken_ex;
  assign ev_lu     = ev_free & ~hz.branch_taken_ex & lu;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = RUN;
    if (ev_excp) begin
      state_nxt = mem_busy ? MEM_WAIT : RUN;
    end else if (ev_mem) begin
      state_nxt = MEM_WAIT;
    end else if (ev_exwait || ev_start) begin
      state_nxt = EX_WAIT;
    end
  end

  always_comb begin
    ctl_if      = '0;
    ctl_id      = '0;
    ctl_ex      = '0;
    stall_mem_c = 1'b0;
    ex_start_c  = 1'b0;
    fwd_hold_c  = 1'b0;
    if (ev_excp) begin
      ctl_if.flush = 1'b1;
      ctl_id.flush = 1'b1;
      // An outstanding data access keeps the pipe frozen so its response is not lost.
      if (mem_busy) begin
        ctl_if.stall = 1'b1;
        ctl_id.stall = 1'b1;
        ctl_ex.stall = 1'b1;
        stall_mem_c  = 1'b1;
      end else begin
        ctl_ex.flush = 1'b1;
      end
    end else if (ev_mem) begin
      ctl_if.stall = 1'b1;
      ctl_id.stall = 1'b1;
      ctl_ex.stall = 1'b1;
      stall_mem_c  = 1'b1;
    end else if (ev_exwait) begin
      ctl_if.stall = 1'b1;
      ctl_id.stall = 1'b1;
      ctl_ex.stall = 1'b1;
      stall_mem_c  = mem_busy;
      fwd_hold_c   = 1'b1;
    end else if (ev_start) begin
      ctl_if.stall = 1'b1;
      ctl_id.stall = 1'b1;
      ctl_ex.stall = 1'b1;
      ex_start_c   = 1'b1;
    end else if (ev_br) begin
      ctl_if.flush = 1'b1;
      ctl_id.flush = 1'b1;
      ctl_ex.flush = 1'b1;
    end else if (ev_lu) begin
      ctl_if.stall = 1'b1;
      ctl_id.stall = 1'b1;
      ctl_ex.flush = 1'b1;
    end
  end

  // Reset forces the combinational controls low without waiting for an edge.
  assign hz.stall_if  = aresetn & ctl_if.stall;
  assign hz.stall_id  = aresetn & ctl_id.stall;
  assign hz.stall_ex  = aresetn & ctl_ex.stall;
  assign hz.stall_mem = aresetn & stall_mem_c;
  assign hz.bubble_ex = aresetn & ctl_ex.flush;
  assign hz.flush_if  = aresetn & ctl_if.flush;
  assign hz.flush_id  = aresetn & ctl_id.flush;
  assign hz.ex_start  = aresetn & ex_start_c;
  assign hz.fwd_hold  = aresetn & fwd_hold_c;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stall_cnt_q <= '0;
    end else if (ctl_id.stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign hz.stall_cnt = stall_cnt_q;

  hazard_watchdog #(
    .EX_TIMEOUT (EX_TIMEOUT)
  ) u_watchdog (
    .aclk    (aclk),
    .aresetn (aresetn),
    .run     (in_ex | ev_start),
    .clr     (hz.excp_flush),
    .timeout (hz.ex_timeout)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam int TO   = 8;
  localparam int CW   = 4;
  localparam int CMAX = 15;
  // Bit positions of the packed output vector.
  localparam int SI = 9, SD = 8, SE = 7, SM = 6, BU = 5, FI = 4, FD = 3, ST = 2, FH = 1, TB = 0;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  pipe_hazard_ctrl_if #(.CNT_W(CW)) hz ();

  pipe_hazard_ctrl #(.EX_TIMEOUT(TO), .CNT_W(CW)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .hz      (hz)
  );

  int total = 0;
  int bad   = 0;

  logic [9:0] dut_vec;
  assign dut_vec = {hz.stall_if, hz.stall_id, hz.stall_ex, hz.stall_mem, hz.bubble_ex,
                    hz.flush_if, hz.flush_id, hz.ex_start, hz.fwd_hold, hz.ex_timeout};

  // Behavioural model: mode 0 running, 1 waiting on EX unit, 2 waiting on data memory.
  int         m_mode = 0;
  int         m_age  = 0;
  bit         m_to   = 0;
  int         m_cnt  = 0;
  logic [9:0] e;
  int         nmode;
  bit         mem_out;
  bit         luh;

  always @(negedge aclk) begin
    e     = '0;
    nmode = 0;
    if (!aresetn) begin
      m_mode = 0; m_age = 0; m_to = 0; m_cnt = 0;
    end else begin
      luh = hz.memRead_ex && hz.regWriteEn_ex && (hz.rd_no_ex != 0) &&
            ((hz.rj_use_id && hz.rj_no_id == hz.rd_no_ex) ||
             (hz.rk_use_id && hz.rk_no_id == hz.rd_no_ex) ||
             (hz.rd_use_id && hz.rd_no_id == hz.rd_no_ex));
      mem_out = (m_mode == 2) ? !hz.mem_data_ok : (hz.mem_req && !hz.mem_data_ok);
      if (hz.excp_flush) begin
        e[FI] = 1; e[FD] = 1;
        if (mem_out) begin e[SI] = 1; e[SD] = 1; e[SE] = 1; e[SM] = 1; nmode = 2; end
        else e[BU] = 1;
      end else if (mem_out && m_mode != 1) begin
        e[SI] = 1; e[SD] = 1; e[SE] = 1; e[SM] = 1; nmode = 2;
      end else if (m_mode == 1 && (!hz.ex_finish || mem_out)) begin
        e[SI] = 1; e[SD] = 1; e[SE] = 1; e[SM] = mem_out; e[FH] = 1; nmode = 1;
      end else if (m_mode != 1 && hz.ex_multi) begin
        e[SI] = 1; e[SD] = 1; e[SE] = 1; e[ST] = 1; nmode = 1;
      end else if (hz.branch_taken_ex) begin
        e[FI] = 1; e[FD] = 1; e[BU] = 1;
      end else if (luh) begin
        e[SI] = 1; e[SD] = 1; e[BU] = 1;
      end
      e[TB] = m_to;
    end
    total = total + 1;
    if (dut_vec !== e || int'(hz.stall_cnt) != m_cnt) begin
      bad = bad + 1;
      $display("FAIL model t=%0t outs=%b exp=%b cnt=%0d exp_cnt=%0d", $time, dut_vec, e, hz.stall_cnt, m_cnt);
    end
    if (aresetn) begin
      if (hz.excp_flush || !(e[ST] || m_mode == 1)) m_age = 0;
      else begin
        m_age = m_age + 1;
        if (m_age == TO) m_to = 1;
      end
      if (e[SD] && m_cnt < CMAX) m_cnt = m_cnt + 1;
      m_mode = nmode;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total = total + 1;
    if (act != exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    hz.rj_no_id = '0; hz.rk_no_id = '0; hz.rd_no_id = '0;
    hz.rj_use_id = 0; hz.rk_use_id = 0; hz.rd_use_id = 0;
    hz.rd_no_ex = '0; hz.regWriteEn_ex = 0; hz.memRead_ex = 0;
    hz.ex_multi = 0; hz.ex_finish = 0; hz.mem_req = 0; hz.mem_data_ok = 0;
    hz.branch_taken_ex = 0; hz.excp_flush = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    aresetn = 0;
    step();
    step();
    aresetn = 1;
  endtask

  int starts, holds;

  initial begin
    idle_inputs();
    aresetn = 1;
    #1;
    // Load-use
    do_reset();
    settle();
    check("rst_outs", int'(dut_vec), 0);
    check("rst_cnt", int'(hz.stall_cnt), 0);
    step();
    hz.memRead_ex = 1; hz.regWriteEn_ex = 1; hz.rd_no_ex = 5'd4; hz.rj_no_id = 5'd4; hz.rj_use_id = 1;
    settle();
    check("lu_stall", int'(dut_vec), 'b1100100000);
    step(); idle_inputs(); settle();
    check("lu_after", int'(dut_vec), 0);
    step();
    hz.memRead_ex = 1; hz.regWriteEn_ex = 1; hz.rd_no_ex = 5'd0; hz.rj_no_id = 5'd0; hz.rj_use_id = 1;
    settle();
    check("lu_r0", int'(dut_vec), 0);
    step();
    hz.rd_no_ex = 5'd7; hz.rj_no_id = 5'd3; hz.rk_no_id = 5'd7; hz.rk_use_id = 0;
    settle();
    check("lu_nouse", int'(dut_vec), 0);
    step();
    hz.rd_no_id = 5'd7; hz.rd_use_id = 1;
    settle();
    check("lu_rd", int'(dut_vec), 'b1100100000);
    step(); idle_inputs();

    // Divide, finish after ten wait cycles
    do_reset();
    starts = 0; holds = 0;
    step(); hz.ex_multi = 1; settle();
    check("div_start0", int'(hz.ex_start), 1);
    starts += int'(hz.ex_start); holds += int'(hz.fwd_hold);
    for (int c = 1; c <= 10; c++) begin
      step(); settle();
      starts += int'(hz.ex_start); holds += int'(hz.fwd_hold);
    end
    step(); hz.ex_finish = 1; settle();
    check("div_fin_stall", int'({hz.stall_if, hz.stall_id, hz.stall_ex}), 0);
    starts += int'(hz.ex_start); holds += int'(hz.fwd_hold);
    step(); hz.ex_multi = 0; hz.ex_finish = 0; settle();
    check("div_starts", starts, 1);
    check("div_hold", holds, 10);
    check("div_cnt", int'(hz.stall_cnt), 11);

    // Memory wait with a taken branch held in EX
    do_reset();
    step(); hz.mem_req = 1; hz.branch_taken_ex = 1; settle();
    check("mb_c0", int'(dut_vec), 'b1111000000);
    for (int c = 1; c <= 2; c++) begin
      step(); settle();
      check("mb_stall", int'(dut_vec), 'b1111000000);
    end
    step(); hz.mem_data_ok = 1; settle();
    check("mb_flush", int'(dut_vec), 'b0000111000);
    step(); idle_inputs();

    // Branch alongside a multi-cycle op: flush deferred to finish
    do_reset();
    step(); hz.ex_multi = 1; hz.branch_taken_ex = 1; settle();
    check("bm_start", int'(dut_vec), 'b1110000100);
    for (int c = 1; c <= 2; c++) begin
      step(); settle();
      check("bm_wait", int'(dut_vec), 'b1110000010);
    end
    step(); hz.ex_finish = 1; settle();
    check("bm_flush", int'(dut_vec), 'b0000111000);
    step(); idle_inputs();

    // Memory wait then a multi-cycle op still waiting in EX
    do_reset();
    step(); hz.mem_req = 1; hz.ex_multi = 1; settle();
    check("mm_mem", int'(dut_vec), 'b1111000000);
    step(); hz.mem_data_ok = 1; settle();
    check("mm_start", int'(dut_vec), 'b1110000100);
    step(); hz.mem_req = 0; hz.mem_data_ok = 0; settle();
    check("mm_wait", int'(dut_vec), 'b1110000010);
    step(); hz.ex_finish = 1; settle();
    check("mm_done", int'(dut_vec), 0);
    step(); idle_inputs();

    // Exception in EX_WAIT, fresh watchdog, then async reset mid-wait
    do_reset();
    step(); hz.ex_multi = 1;
    for (int c = 1; c <= 3; c++) step();
    step(); hz.excp_flush = 1; settle();
    check("ex_flush", int'(dut_vec), 'b0000111000);
    step(); hz.excp_flush = 0; hz.ex_multi = 0; settle();
    check("ex_run", int'(dut_vec), 0);
    step(); hz.ex_multi = 1;
    for (int c = 1; c <= 7; c++) step();
    settle();
    check("wd_pre", int'(hz.ex_timeout), 0);
    step(); settle();
    check("wd_set", int'(hz.ex_timeout), 1);
    step(); step(); settle();
    check("wd_sticky", int'(hz.ex_timeout), 1);
    aresetn = 0;
    #1;
    check("arst_outs", int'(dut_vec), 0);
    check("arst_cnt", int'(hz.stall_cnt), 0);

    // Stall counter saturation
    do_reset();
    step(); hz.mem_req = 1;
    for (int c = 1; c <= 20; c++) begin
      step(); settle();
      if (c == 14) check("sat_14", int'(hz.stall_cnt), 14);
      if (c == 20) check("sat_hold", int'(hz.stall_cnt), 15);
    end
    step(); hz.mem_data_ok = 1;
    step(); idle_inputs();
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
